led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Drives the board LED from the slow divided square wave produced by the LFOSC ripple-divider stage, replacing the raw divider bit on the LED pin. The block synchronises the divider output into the 10 kHz LFOSC clock domain and turns each rising edge into a one-cycle tick. Each tick steps through a loadable 8-step on/off pattern, and a 4-bit PWM sets brightness. It sits directly downstream of the divider and upstream of the `led` pad.

## Interface
- `PATTERN_RESET`, default 8'h55: pattern register value after reset (alternating on/off, i.e. plain blink).
- `ARM_CYCLES`, default 3: clk cycles after reset release during which ticks are suppressed.
- `clk`  in  1  10 kHz SB_LFOSC clock; the single clock of the block.
- `rst`  in  1  reset, asynchronous, active-low; assertion clears all state immediately, release is sampled on `clk`.
- `div_in`  in  1  divided square wave from the ripple divider (MSB stage); asynchronous to `clk`.
- `enable`  in  1  1 = sequencer running, 0 = idle with LED dark.
- `pattern_in`  in  8  new pattern; bit n is the LED state for step n.
- `load`  in  1  single-cycle strobe; captures `pattern_in`.
- `duty`  in  4  PWM on-count per 16 clk cycles (0 = off, 15 = 15/16).
- `led`  out  1  registered LED drive.
- `step`  out  3  current pattern index.
- `tick`  out  1  registered one-cycle pulse per detected `div_in` rising edge.

## Operation
- Synchroniser: two flops `s1`, `s2` (reset 0), then edge flop `prev` (reset 0). `prev` is loaded from `s2` every cycle.
- Arm counter: 2-bit counter, reset 0, increments each cycle until it reaches `ARM_CYCLES`, then saturates. Until saturated, `tick` is forced to 0. This suppresses a spurious edge when `div_in` is high at reset release.
- `tick` is registered: next value = armed & `s2` & ~`prev`.
- FSM, two states:
  - IDLE (reset state). Moves to RUN when `enable`=1.
  - RUN. Moves to IDLE when `enable`=0.
  - On the IDLE→RUN transition, `step` is set to 0.
  - In IDLE, `step` holds its value and `led` is 0.
- Step counter (RUN only): on `tick`, `step` increments modulo 8 (7→0 wraps).
- Pattern register, reset value `PATTERN_RESET`:
  - When `load`=1, `pattern_reg` takes `pattern_in` and `step` is set to 0, in both FSM states.
  - `load` has priority over the tick advance and over the IDLE→RUN clear; the result is identical in every case (step=0).
- PWM:
  - 4-bit free-running `pwm_cnt`, reset 0, increments every cycle, wraps 15→0 regardless of state.
  - `pwm_on` = (`pwm_cnt` < `duty`), unsigned 4-bit compare.
- Output: `led` next value = (state==RUN) & `pattern_reg[step]` & `pwm_on`. It uses the current-cycle register values.
- `tick` is produced whether or not the FSM is in RUN. It is observable for debug.

## Timing
- Reset values: `led`=0, `step`=0, `tick`=0, FSM=IDLE, `pattern_reg`=`PATTERN_RESET`, `pwm_cnt`=0, arm counter=0.
- Reset asserted mid-operation clears all outputs without waiting for a clock edge.
- Latency, `div_in`↑ to `tick`: `div_in` rises before clk edge E1 (setup met). `s1`=1 after E1, `s2`=1 after E2, `tick`=1 after E3, `tick`=0 after E4. Exactly one cycle high per rising edge.
- Latency, `tick` to `step`: `step` updates on the edge after the cycle in which `tick`=1.
- Latency, `step` to `led`: one further cycle.
- `div_in` pulse narrower than one clk period may be missed. The divider output period is 2^13 clk cycles, so this does not occur in normal use.
- `tick` and `load` in the same cycle: `step`=0, the new pattern is taken, and the tick is consumed (no advance).
- `enable` falling: FSM goes to IDLE on the next edge, and `led`=0 one edge later.
- `duty` changes take effect on the next compare, with no period resynchronisation.

## Test plan
- Reset with `div_in`=1, `enable`=1:
  - no `tick` during the first `ARM_CYCLES`;
  - `led`=0 until `div_in` toggles.
- `duty`=15, `enable`=1, default pattern, `div_in` toggling every 40 clk:
  - `step` advances 0→1→…→7→0;
  - `led` follows 8'h55 bit by bit with 15/16 on-cycles;
  - `tick`↑ exactly 3 edges after each `div_in`↑.
- `load` with `pattern_in`=8'hF0 in the same cycle as `tick`:
  - `step`=0 next cycle;
  - `led`=0 for steps 0–3 and PWM-on for steps 4–7.
- PWM: `duty`=0 gives `led` always 0; `duty`=4 gives exactly 4 high cycles per 16 during an on-step.
- `enable` dropped at `step`=5:
  - `led`=0 within 2 edges;
  - `step` stays 5 while ticks continue;
  - after re-enable, `step`=0.
- Assert `rst` asynchronously mid-pattern: all outputs go to reset values before the next `clk` edge, and the pattern returns to 8'h55.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
// Control and status bundle between the LED sequencer and whatever drives it.
// The master side supplies the divider wave, enable, pattern load and duty;
// the slave side (the sequencer) returns the LED drive, step index and tick.
interface led_pattern_sequencer_if;
    logic       div_in;
    logic       enable;
    logic [7:0] pattern_in;
    logic       load;
    logic [3:0] duty;
    logic       led;
    logic [2:0] step;
    logic       tick;

    modport master (
        output div_in, enable, pattern_in, load, duty,
        input  led, step, tick
    );

    modport slave (
        input  div_in, enable, pattern_in, load, duty,
        output led, step, tick
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer for the LFOSC domain.
// Synchronises the slow ripple-divider square wave, turns each rising edge
// into a one-cycle tick, steps through an 8-entry on/off pattern on each tick
// and gates the LED with a 4-bit free-running PWM for brightness control.
module led_pattern_sequencer #(
    parameter logic [7:0]  PATTERN_RESET = 8'h55,
    parameter int unsigned ARM_CYCLES    = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    led_pattern_sequencer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The arm counter is only two bits wide, so the limit is taken modulo 4.
    localparam logic [1:0] ARM_LIMIT = 2'(ARM_CYCLES);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] arm_q;
    logic [1:0] arm_d;
    logic       armed;
    logic       tick_q;
    logic       tick_d;
    logic [3:0] pwm_cnt_q;
    logic [3:0] pwm_cnt_d;
    logic       pwm_on;
    state_t     state_q;
    logic [2:0] step_q;
    logic [7:0] pattern_q;
    logic       led_q;

    assign armed     = (arm_q == ARM_LIMIT);
    assign arm_d     = armed ? arm_q : arm_q + 2'd1;
    assign tick_d    = armed & s2_q & ~prev_q;
    assign pwm_cnt_d = pwm_cnt_q + 4'd1;
    assign pwm_on    = (pwm_cnt_q < bus.duty);

    // Two-flop synchroniser for the asynchronous divider wave plus the edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= bus.div_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Arm counter hides a false edge when the divider is already high at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q  <= 2'd0;
            tick_q <= 1'b0;
        end else begin
            arm_q  <= arm_d;
            tick_q <= tick_d;
        end
    end

    // Free-running PWM phase counter, independent of the sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 4'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Sequencer FSM with pattern register, step index and registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            pattern_q <= PATTERN_RESET;
            led_q     <= 1'b0;
        end else begin
            led_q <= (state_q == RUN) & pattern_q[step_q] & pwm_on;

            if (state_q == IDLE) begin
                if (bus.enable) begin
                    state_q <= RUN;
                end
            end else begin
                if (!bus.enable) begin
                    state_q <= IDLE;
                end
            end

            if (bus.load) begin
                pattern_q <= bus.pattern_in;
            end

            if (bus.load) begin
                step_q <= 3'd0;
            end else if ((state_q == IDLE) && bus.enable) begin
                step_q <= 3'd0;
            end else if ((state_q == RUN) && tick_q) begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.step = step_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for the LED pattern sequencer: a hand-computed vector table right after
// reset, directed multi-cycle sequences, then randomized traffic, all compared
// against a history-based reference model of the sequencer's behaviour.
module tb_led_pattern_sequencer;

    localparam int ARM = 3;

    typedef struct {
        logic       divIn;
        logic       enable;
        logic       load;
        logic [7:0] pattern;
        logic [3:0] duty;
        logic       expLed;
        logic [2:0] expStep;
        logic       expTick;
    } vector_t;

    logic clk;
    logic rst_n;

    led_pattern_sequencer_if seqBus();

    led_pattern_sequencer #(
        .PATTERN_RESET (8'h55),
        .ARM_CYCLES    (ARM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (seqBus)
    );

    // 10-unit clock period stands in for the LFOSC clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    logic       drvDiv     = 1'b0;
    logic       drvEnable  = 1'b0;
    logic       drvLoad    = 1'b0;
    logic [7:0] drvPattern = 8'h00;
    logic [3:0] drvDuty    = 4'd0;
    int         divCnt     = 0;

    // Reference model: edges counted since reset release, every sampled
    // divider level kept in a queue, and the visible outputs after the edge.
    int         edgeNum;
    int         lastRiseEdge;
    bit         lastDiv;
    bit         divHist[$];
    bit         mTick;
    bit         mRun;
    bit         mLed;
    int         mStep;
    logic [7:0] mPattern;

    vector_t vectors[15];

    task automatic checkValue(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, edgeNum);
        end
    endtask

    function automatic bit sampleAt(input int k);
        if (k >= 1 && k <= divHist.size()) return divHist[k-1];
        return 1'b0;
    endfunction

    task automatic modelReset();
        edgeNum      = 0;
        lastRiseEdge = -100;
        lastDiv      = 1'b0;
        divHist.delete();
        mTick        = 1'b0;
        mRun         = 1'b0;
        mLed         = 1'b0;
        mStep        = 0;
        mPattern     = 8'h55;
    endtask

    // One clock edge of the behavioural model, using the inputs held across it.
    task automatic modelEdge();
        bit newTick;
        bit newLed;
        int newStep;
        edgeNum++;
        if (drvDiv && !lastDiv) lastRiseEdge = edgeNum;
        lastDiv = drvDiv;
        divHist.push_back(drvDiv);
        // A rise seen at edge k becomes visible as a tick after edge k+2.
        newTick = (edgeNum > ARM) && sampleAt(edgeNum - 2) && !sampleAt(edgeNum - 3);
        newLed  = mRun && mPattern[mStep] && (((edgeNum - 1) % 16) < int'(drvDuty));
        if (drvLoad)                newStep = 0;
        else if (!mRun && drvEnable) newStep = 0;
        else if (mRun && mTick)      newStep = (mStep + 1) % 8;
        else                         newStep = mStep;
        if (drvLoad) mPattern = drvPattern;
        mRun  = drvEnable;
        mStep = newStep;
        mTick = newTick;
        mLed  = newLed;
    endtask

    task automatic checkOutput();
        checkValue("led",  int'(seqBus.led),  int'(mLed));
        checkValue("step", int'(seqBus.step), mStep);
        checkValue("tick", int'(seqBus.tick), int'(mTick));
        if (seqBus.tick === 1'b1) checkValue("tickLatency", edgeNum - lastRiseEdge, 2);
    endtask

    // Drive the current inputs for one clock, advance the model, then compare.
    task automatic applyStimulus();
        seqBus.div_in     = drvDiv;
        seqBus.enable     = drvEnable;
        seqBus.load       = drvLoad;
        seqBus.pattern_in = drvPattern;
        seqBus.duty       = drvDuty;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    // Run cycles with the divider toggling every 'half' clocks.
    task automatic runTicking(input int cycles, input int half);
        for (int c = 0; c < cycles; c++) begin
            if (divCnt >= half - 1) begin
                drvDiv = ~drvDiv;
                divCnt = 0;
            end else begin
                divCnt++;
            end
            applyStimulus();
        end
    endtask

    // Assert reset between edges, confirm outputs clear immediately, then release.
    task automatic doAsyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("asyncLed",  int'(seqBus.led),  0);
        checkValue("asyncStep", int'(seqBus.step), 0);
        checkValue("asyncTick", int'(seqBus.tick), 0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int prevStep;
        int changes;
        int highCount;
        int tickCount;
        int randCnt;

        for (int i = 0; i < 6; i++) vectors[i] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0};
        vectors[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd15, 1'b1, 3'd0, 1'b0};
        vectors[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd15, 1'b1, 3'd0, 1'b0};
        vectors[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd15, 1'b1, 3'd0, 1'b0};
        vectors[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd15, 1'b1, 3'd0, 1'b1};
        vectors[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd15, 1'b1, 3'd1, 1'b0};
        vectors[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd15, 1'b0, 3'd1, 1'b0};
        vectors[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd15, 1'b0, 3'd1, 1'b0};
        vectors[13] = '{1'b0, 1'b1, 1'b1, 8'hF0, 4'd15, 1'b0, 3'd0, 1'b0};
        vectors[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd15, 1'b0, 3'd0, 1'b0};

        seqBus.div_in     = 1'b1;
        seqBus.enable     = 1'b1;
        seqBus.load       = 1'b0;
        seqBus.pattern_in = 8'h00;
        seqBus.duty       = 4'd0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        modelReset();
        #2;
        checkValue("resetLed",  int'(seqBus.led),  0);
        checkValue("resetStep", int'(seqBus.step), 0);
        checkValue("resetTick", int'(seqBus.tick), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] vector table after reset release, divider high");
        for (int i = 0; i < 15; i++) begin
            drvDiv     = vectors[i].divIn;
            drvEnable  = vectors[i].enable;
            drvLoad    = vectors[i].load;
            drvPattern = vectors[i].pattern;
            drvDuty    = vectors[i].duty;
            applyStimulus();
            checkValue("vecLed",  int'(seqBus.led),  int'(vectors[i].expLed));
            checkValue("vecStep", int'(seqBus.step), int'(vectors[i].expStep));
            checkValue("vecTick", int'(seqBus.tick), int'(vectors[i].expTick));
        end
        drvLoad = 1'b0;

        $display("[TB] async reset mid-pattern restores default pattern");
        divCnt = 0;
        runTicking(200, 40);
        doAsyncReset();
        drvDiv    = 1'b0;
        drvEnable = 1'b1;
        drvDuty   = 4'd15;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkValue("defaultPatternLed",  int'(seqBus.led),  1);
        checkValue("defaultPatternStep", int'(seqBus.step), 0);

        $display("[TB] step walk with divider toggling every 40 clocks");
        divCnt   = 0;
        changes  = 0;
        prevStep = int'(seqBus.step);
        for (int c = 0; c < 730; c++) begin
            runTicking(1, 40);
            if (int'(seqBus.step) != prevStep) begin
                checkValue("stepOrder", int'(seqBus.step), (prevStep + 1) % 8);
                changes++;
                prevStep = int'(seqBus.step);
            end
        end
        checkValue("stepAdvances", int'(changes >= 8), 1);

        $display("[TB] load coinciding with tick");
        for (int c = 0; c < 200 && !mTick; c++) runTicking(1, 40);
        checkValue("tickSeen", int'(seqBus.tick), 1);
        drvLoad    = 1'b1;
        drvPattern = 8'hF0;
        runTicking(1, 40);
        drvLoad = 1'b0;
        checkValue("loadStep", int'(seqBus.step), 0);
        for (int c = 0; c < 730; c++) begin
            prevStep = int'(seqBus.step);
            runTicking(1, 40);
            if (prevStep < 4) checkValue("ledOffLowSteps", int'(seqBus.led), 0);
        end

        $display("[TB] PWM duty 4 and duty 0 on an all-on pattern");
        drvLoad    = 1'b1;
        drvPattern = 8'hFF;
        drvDuty    = 4'd4;
        applyStimulus();
        drvLoad = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus();
        highCount = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            if (seqBus.led === 1'b1) highCount++;
        end
        checkValue("duty4High", highCount, 4);
        drvDuty = 4'd0;
        for (int i = 0; i < 2; i++) applyStimulus();
        highCount = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            if (seqBus.led === 1'b1) highCount++;
        end
        checkValue("duty0High", highCount, 0);

        $display("[TB] enable dropped at step 5");
        drvLoad    = 1'b1;
        drvPattern = 8'h55;
        drvDuty    = 4'd15;
        applyStimulus();
        drvLoad = 1'b0;
        divCnt  = 0;
        for (int c = 0; c < 1200 && seqBus.step != 3'd5; c++) runTicking(1, 40);
        checkValue("reachStep5", int'(seqBus.step), 5);
        drvEnable = 1'b0;
        runTicking(2, 40);
        checkValue("ledOffAfterDisable", int'(seqBus.led), 0);
        tickCount = 0;
        for (int c = 0; c < 400; c++) begin
            runTicking(1, 40);
            if (seqBus.tick === 1'b1) tickCount++;
        end
        checkValue("idleStepHeld", int'(seqBus.step), 5);
        checkValue("idleTicksSeen", int'(tickCount >= 4), 1);
        drvEnable = 1'b1;
        runTicking(1, 40);
        checkValue("reenableStep", int'(seqBus.step), 0);

        $display("[TB] randomized traffic");
        randCnt = 5;
        for (int c = 0; c < 3000; c++) begin
            if (randCnt == 0) begin
                drvDiv  = ~drvDiv;
                randCnt = $urandom_range(3, 20);
            end else begin
                randCnt--;
            end
            if ($urandom_range(0, 199) == 0) drvEnable = ~drvEnable;
            drvLoad = ($urandom_range(0, 49) == 0);
            if (drvLoad) drvPattern = 8'($urandom);
            if ($urandom_range(0, 29) == 0) drvDuty = 4'($urandom);
            applyStimulus();
            if (c == 1500) doAsyncReset();
        end
        drvLoad = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
